// File: rtl/matrix_pkg.sv
// Shared types and default geometry for the matrix write sequencer.
package matrix_pkg;

   localparam int DIM    = 32;
   localparam int ELEM_W = 8;
   localparam int ADDR_W = $clog2(DIM);

   typedef enum logic [2:0] {
      IDLE,
      EVEN,
      ODD,
      DRAIN,
      DONE
   } seq_state_t;

   // Tag carried alongside an outstanding read at the default geometry.
   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] row;
      logic [ADDR_W-1:0] col;
   } elem_tag_t;

endpackage

// File: rtl/matrix_write_sequencer_scan.sv
// Parity-interleaved row/col walker: even columns first, then odd columns,
// rows descending from DIM-1 to 0 inside each column.
module matrix_scan_counter #(
   parameter int  DIM = matrix_pkg::DIM,
   localparam int AW  = $clog2(DIM)
) (
   input  logic          inter_refclk,
   input  logic          rst,
   input  logic          step,
   input  logic          clear,
   output logic [AW-1:0] row,
   output logic [AW-1:0] col,
   output logic          last_in_pass,
   output logic          last_in_frame
);

   localparam logic [AW-2:0] PAIR_MAX = '1;
   localparam logic [AW-1:0] ROW_TOP  = '1;

   // col = {pair, parity}: the pair index walks within one parity pass.
   logic [AW-1:0] row_q;
   logic [AW-2:0] pair_q;
   logic          parity_q;

   assign row           = row_q;
   assign col           = {pair_q, parity_q};
   assign last_in_pass  = (row_q == '0) && (pair_q == PAIR_MAX);
   assign last_in_frame = last_in_pass && parity_q;

   // Advance one element per step; all fields wrap naturally at DIM.
   always_ff @(posedge inter_refclk or posedge rst) begin
      if (rst) begin
         row_q    <= ROW_TOP;
         pair_q   <= '0;
         parity_q <= 1'b0;
      end else if (clear) begin
         row_q    <= ROW_TOP;
         pair_q   <= '0;
         parity_q <= 1'b0;
      end else if (step) begin
         row_q <= row_q - 1'b1;
         if (row_q == '0) begin
            pair_q <= pair_q + 1'b1;
            if (pair_q == PAIR_MAX) begin
               parity_q <= ~parity_q;
            end
         end
      end
   end

endmodule

// File: rtl/matrix_write_sequencer.sv
// Reads a DIM x DIM element store in compiler order and presents each element
// with its row/col address, then pulses done and counts the frame.
//
//   state | meaning
//   IDLE  | waiting for start
//   EVEN  | issuing reads over even columns
//   ODD   | issuing reads over odd columns
//   DRAIN | all reads issued, waiting for in-flight data to be presented
//   DONE  | one-cycle done pulse, frame counted
module matrix_write_sequencer #(
   parameter int  DIM         = matrix_pkg::DIM,
   parameter int  ELEM_W      = matrix_pkg::ELEM_W,
   parameter int  MEM_LATENCY = 2,
   parameter int  CNT_W       = 16,
   localparam int AW          = $clog2(DIM)
) (
   input  logic              inter_refclk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              pause,
   output logic              mem_rd_en,
   output logic [2*AW-1:0]   mem_addr,
   input  logic [ELEM_W-1:0] mem_data,
   output logic              valid_data_out,
   output logic [AW-1:0]     row_addr,
   output logic [AW-1:0]     col_addr,
   output logic [ELEM_W-1:0] matrix_element,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  frame_count
);

   import matrix_pkg::*;

   typedef struct packed {
      logic          valid;
      logic [AW-1:0] row;
      logic [AW-1:0] col;
   } tag_t;

   seq_state_t    state_q, state_d;
   logic          issue, clear_scan, count_frame, kill, in_flight;
   logic [AW-1:0] scan_row, scan_col;
   logic          last_in_pass, last_in_frame;
   tag_t          pipe_q [MEM_LATENCY];

   matrix_scan_counter #(.DIM(DIM)) u_scan (
      .inter_refclk (inter_refclk),
      .rst          (rst),
      .step         (issue),
      .clear        (clear_scan),
      .row          (scan_row),
      .col          (scan_col),
      .last_in_pass (last_in_pass),
      .last_in_frame(last_in_frame)
   );

   assign kill = abort && (state_q != IDLE);
   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);

   // Anything still travelling toward the outputs blocks the exit from DRAIN.
   always_comb begin
      in_flight = mem_rd_en;
      for (int i = 0; i < MEM_LATENCY; i++) begin
         in_flight = in_flight | pipe_q[i].valid;
      end
   end

   // State register.
   always_ff @(posedge inter_refclk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state and per-cycle controls; abort outranks start and pause.
   always_comb begin
      state_d     = state_q;
      issue       = 1'b0;
      clear_scan  = 1'b0;
      count_frame = 1'b0;
      if (kill) begin
         state_d    = IDLE;
         clear_scan = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (start && !abort) begin
                  state_d    = EVEN;
                  clear_scan = 1'b1;
               end
            end
            EVEN: begin
               if (!pause) begin
                  issue = 1'b1;
                  if (last_in_pass) state_d = ODD;
               end
            end
            ODD: begin
               if (!pause) begin
                  issue = 1'b1;
                  if (last_in_frame) state_d = DRAIN;
               end
            end
            DRAIN: begin
               if (!in_flight) begin
                  state_d     = DONE;
                  count_frame = 1'b1;
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Read strobe, latency pipeline carrying the address tag, and output capture.
   always_ff @(posedge inter_refclk or posedge rst) begin
      if (rst) begin
         mem_rd_en      <= 1'b0;
         mem_addr       <= '0;
         valid_data_out <= 1'b0;
         row_addr       <= '0;
         col_addr       <= '0;
         matrix_element <= '0;
         frame_count    <= '0;
         for (int i = 0; i < MEM_LATENCY; i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         mem_rd_en <= issue;
         if (issue) begin
            mem_addr <= {scan_row, scan_col};
         end
         pipe_q[0].valid <= mem_rd_en & ~kill;
         pipe_q[0].row   <= mem_addr[2*AW-1:AW];
         pipe_q[0].col   <= mem_addr[AW-1:0];
         for (int i = MEM_LATENCY - 1; i > 0; i--) begin
            pipe_q[i].valid <= pipe_q[i-1].valid & ~kill;
            pipe_q[i].row   <= pipe_q[i-1].row;
            pipe_q[i].col   <= pipe_q[i-1].col;
         end
         valid_data_out <= pipe_q[MEM_LATENCY-1].valid & ~kill;
         if (pipe_q[MEM_LATENCY-1].valid && !kill) begin
            row_addr       <= pipe_q[MEM_LATENCY-1].row;
            col_addr       <= pipe_q[MEM_LATENCY-1].col;
            matrix_element <= mem_data;
         end
         if (count_frame) begin
            frame_count <= frame_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_matrix_write_sequencer.sv
// Bench for matrix_write_sequencer: three instances (read latency 1, 2, 4)
// share one stimulus stream; a frame-level model predicts every output.
`timescale 1ns/1ps
module tb_matrix_write_sequencer;

   localparam int DIM = 32;
   localparam int AW  = 5;
   localparam int N   = DIM * DIM;
   localparam int NI  = 3;

   logic clk = 1'b0;
   logic rst, start, abort, pause;

   logic            d_rd   [NI];
   logic [2*AW-1:0] d_addr [NI];
   logic [7:0]      d_mdat [NI];
   logic            d_vld  [NI];
   logic [AW-1:0]   d_row  [NI];
   logic [AW-1:0]   d_col  [NI];
   logic [7:0]      d_elem [NI];
   logic            d_busy [NI];
   logic            d_done [NI];
   logic [15:0]     d_fc   [NI];

   always #5 clk = ~clk;

   function automatic int lat_of(input int i);
      return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
   endfunction

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int L = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
      logic [7:0] mpipe [L];

      matrix_write_sequencer #(.DIM(DIM), .ELEM_W(8), .MEM_LATENCY(L), .CNT_W(16)) u_dut (
         .inter_refclk  (clk),
         .rst           (rst),
         .start         (start),
         .abort         (abort),
         .pause         (pause),
         .mem_rd_en     (d_rd[g]),
         .mem_addr      (d_addr[g]),
         .mem_data      (d_mdat[g]),
         .valid_data_out(d_vld[g]),
         .row_addr      (d_row[g]),
         .col_addr      (d_col[g]),
         .matrix_element(d_elem[g]),
         .busy          (d_busy[g]),
         .done          (d_done[g]),
         .frame_count   (d_fc[g])
      );

      // Element store: returns {col[3:0], row[3:0]} L cycles after the read.
      always @(posedge clk) begin
         mpipe[0] <= d_rd[g] ? {d_addr[g][3:0], d_addr[g][AW+3:AW]} : 8'h00;
         for (int s = 1; s < L; s++) mpipe[s] <= mpipe[s-1];
      end
      assign d_mdat[g] = mpipe[L-1];
   end

   // Compiler order: index k -> (row, col).
   function automatic int idx_row(input int k);
      return DIM - 1 - (k % DIM);
   endfunction
   function automatic int idx_col(input int k);
      return 2 * ((k % (N / 2)) / DIM) + (k / (N / 2));
   endfunction

   // ---------------- frame-level model ----------------
   int t;
   bit m_active  [NI];
   int m_k       [NI];
   int m_done_cyc[NI];
   int m_fc      [NI];
   bit m_rd      [NI];
   int m_rd_idx  [NI];
   int m_sched   [NI][16];
   bit m_vld     [NI];
   int m_row     [NI];
   int m_col     [NI];
   int m_elem    [NI];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         t = 0;
         for (int i = 0; i < NI; i++) begin
            m_active[i] = 0; m_k[i] = 0; m_done_cyc[i] = -1; m_fc[i] = 0;
            m_rd[i] = 0; m_rd_idx[i] = 0; m_vld[i] = 0;
            m_row[i] = 0; m_col[i] = 0; m_elem[i] = 0;
            for (int s = 0; s < 16; s++) m_sched[i][s] = -1;
         end
      end else begin
         t = t + 1;
         for (int i = 0; i < NI; i++) begin
            int lat;
            bit was;
            lat = lat_of(i);
            was = m_active[i];
            m_rd[i] = 0;
            if (was && abort) begin
               m_active[i] = 0;
               m_done_cyc[i] = -1;
               for (int s = 0; s < 16; s++) m_sched[i][s] = -1;
            end else if (was) begin
               if (m_done_cyc[i] >= 0 && t == m_done_cyc[i] + 1) begin
                  m_active[i] = 0;
               end else if (m_k[i] < N && !pause) begin
                  m_rd[i] = 1;
                  m_rd_idx[i] = m_k[i];
                  m_sched[i][(t + lat + 1) % 16] = m_k[i];
                  m_k[i] = m_k[i] + 1;
                  if (m_k[i] == N) m_done_cyc[i] = t + lat + 2;
               end
               if (t == m_done_cyc[i]) m_fc[i] = m_fc[i] + 1;
            end else if (start && !abort) begin
               m_active[i] = 1;
               m_k[i] = 0;
               m_done_cyc[i] = -1;
            end
            if (m_sched[i][t % 16] >= 0) begin
               m_vld[i]  = 1;
               m_row[i]  = idx_row(m_sched[i][t % 16]);
               m_col[i]  = idx_col(m_sched[i][t % 16]);
               m_elem[i] = ((m_col[i] & 15) << 4) | (m_row[i] & 15);
               m_sched[i][t % 16] = -1;
            end else begin
               m_vld[i] = 0;
            end
         end
      end
   end

   // ---------------- comparison ----------------
   int n_cmp = 0;
   int n_bad = 0;
   int tmo = 0;
   bit end_req = 0;
   bit lit_en = 0;
   int lit_base = 0;
   int lit_pause = 0;
   int lit_fc = 0;
   int lit_vc = 0;

   task automatic check(input string name, input int inst, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s (lat %0d) cycle %0d: got %0d, expected %0d",
                  name, lat_of(inst), t, act, exp);
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < NI; i++) begin
         check("busy", i, d_busy[i], m_active[i]);
         check("done", i, d_done[i], (m_active[i] && t == m_done_cyc[i]) ? 1 : 0);
         check("frame_count", i, d_fc[i], m_fc[i] % 65536);
         check("mem_rd_en", i, d_rd[i], m_rd[i]);
         if (m_rd[i])
            check("mem_addr", i, d_addr[i], idx_row(m_rd_idx[i]) * DIM + idx_col(m_rd_idx[i]));
         check("valid", i, d_vld[i], m_vld[i]);
         check("row_addr", i, d_row[i], m_row[i]);
         check("col_addr", i, d_col[i], m_col[i]);
         check("element", i, d_elem[i], m_elem[i]);
      end
      // Hand-computed anchors on the latency-2 instance.
      if (lit_en && t >= lit_base && t <= lit_base + 1100) begin
         if (t == lit_base) lit_vc = 0;
         if (t == lit_base + 3) check("lit_no_early_valid", 1, d_vld[1], 0);
         if (d_vld[1]) begin
            lit_vc++;
            if (lit_vc == 1) begin
               check("lit_first_cycle", 1, t - lit_base, 4);
               check("lit_first_row", 1, d_row[1], 31);
               check("lit_first_col", 1, d_col[1], 0);
               check("lit_first_elem", 1, d_elem[1], 8'h0F);
            end
            if (lit_vc == 512) begin
               check("lit_512_row", 1, d_row[1], 0);
               check("lit_512_col", 1, d_col[1], 30);
            end
            if (lit_vc == 513) begin
               check("lit_513_row", 1, d_row[1], 31);
               check("lit_513_col", 1, d_col[1], 1);
            end
            if (lit_vc == 1024) begin
               check("lit_last_row", 1, d_row[1], 0);
               check("lit_last_col", 1, d_col[1], 31);
               check("lit_last_elem", 1, d_elem[1], 8'hF0);
               check("lit_last_cycle", 1, t - lit_base, 1027 + lit_pause);
            end
         end
         if (t == lit_base + 1028 + lit_pause) begin
            check("lit_done", 1, d_done[1], 1);
            check("lit_frame_count", 1, d_fc[1], lit_fc);
            check("lit_valid_count", 1, lit_vc, 1024);
         end
      end
      if (end_req) begin
         check("wait_timeouts", 0, tmo, 0);
         $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
         $finish;
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_idle(input int budget);
      int c;
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while ((d_busy[0] || d_busy[1] || d_busy[2]) && c < budget);
      if (c >= budget) tmo++;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic pulse_start_lit(input int pause_len, input int fc);
      lit_pause = pause_len;
      lit_fc = fc;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      lit_base = t;
      lit_en = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic random_frame(input int budget);
      int c;
      c = 0;
      pulse_start();
      while ((d_busy[0] || d_busy[1] || d_busy[2]) && c < budget) begin
         @(negedge clk);
         c++;
         pause = ($urandom_range(0, 5) == 0);
         start = ($urandom_range(0, 60) == 0);
      end
      pause = 1'b0;
      start = 1'b0;
      wait_idle(3000);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Clean frame.
      pulse_start_lit(0, 1);
      wait_idle(1200);
      repeat (3) @(negedge clk);
      lit_en = 1'b0;

      // Ten-cycle pause in the even pass.
      pulse_start_lit(10, 2);
      repeat (200) @(negedge clk);
      pause = 1'b1;
      repeat (10) @(negedge clk);
      pause = 1'b0;
      wait_idle(1200);
      repeat (3) @(negedge clk);
      lit_en = 1'b0;

      // Abort in the odd pass near element 600, then idle a while.
      pulse_start();
      repeat (598) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      repeat (12) @(negedge clk);

      // Start together with abort while idle: ignored.
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      repeat (8) @(negedge clk);

      // Full frame with random pauses and stray start pulses.
      random_frame(4000);

      // Asynchronous reset mid-frame, released off the clock edge.
      pulse_start();
      repeat (300) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      repeat (4) @(negedge clk);

      // Clean frames after reset.
      random_frame(4000);
      pulse_start();
      wait_idle(1200);
      repeat (4) @(negedge clk);

      end_req = 1'b1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got time %0t, expected under 2 ms", $time);
      $fatal(1, "watchdog");
   end

endmodule
